// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap feeder: widths, tap count,
// FSM state encoding and the legal multicycle window range.
package fir_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RES_W_DEF   = 32;
    localparam int NTAPS       = 6;
    localparam int FIR_LAT_MIN = 1;
    localparam int FIR_LAT_MAX = 4;
    localparam int LAT_CNT_W   = 2;
    localparam int FILL_W      = 3;

    localparam logic [FILL_W-1:0] FILL_FULL = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fir_state_e;

    // Saturating increment of the fill level; stops at a full line.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] fill);
        if (fill >= FILL_FULL) begin
            fill_inc = FILL_FULL;
        end else begin
            fill_inc = fill + 3'd1;
        end
    endfunction

    // Wait-counter load value for a given window; out-of-range windows are clamped.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        if (lat <= FIR_LAT_MIN) begin
            lat_load = {LAT_CNT_W{1'b0}};
        end else if (lat >= FIR_LAT_MAX) begin
            lat_load = LAT_CNT_W'(FIR_LAT_MAX - 1);
        end else begin
            lat_load = LAT_CNT_W'(lat - 1);
        end
    endfunction

endpackage

// File: rtl/fir_tap_shift.sv
// Six-entry tap delay line with a saturating fill counter.
// Entry 0 holds the newest sample; clr zeroes both the line and the counter.
module fir_tap_shift
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift_en,
    input  logic                          clr,
    input  logic [DATA_W-1:0]             din,
    output logic [NTAPS-1:0][DATA_W-1:0]  taps,
    output logic [FILL_W-1:0]             fill_cnt
);

    logic [NTAPS-1:0][DATA_W-1:0] taps_r;
    logic [FILL_W-1:0]            fill_r;

    // Delay line and fill level; clear beats shift, oldest sample falls off the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_r <= {(NTAPS * DATA_W){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (clr) begin
            taps_r <= {(NTAPS * DATA_W){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (shift_en) begin
            taps_r <= {taps_r[NTAPS-2:0], din};
            fill_r <= fill_inc(fill_r);
        end else begin
            taps_r <= taps_r;
            fill_r <= fill_r;
        end
    end

    assign taps     = taps_r;
    assign fill_cnt = fill_r;

endmodule

// File: rtl/fir_tap_feeder.sv
// Feeds the combinational 6-tap FIR datapath: accepts one sample at a time,
// holds the taps stable for FIR_LAT cycles, then captures and offers the result.
module fir_tap_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RES_W        = RES_W_DEF,
    parameter int FIR_LAT      = 1,
    parameter int EMIT_PARTIAL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic [DATA_W-1:0] tap_0,
    output logic [DATA_W-1:0] tap_1,
    output logic [DATA_W-1:0] tap_2,
    output logic [DATA_W-1:0] tap_3,
    output logic [DATA_W-1:0] tap_4,
    output logic [DATA_W-1:0] tap_5,
    input  logic [RES_W-1:0]  fir_result,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RES_W-1:0]  m_data,
    output logic [2:0]        fill_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(FIR_LAT);

    fir_state_e                   state_r;
    fir_state_e                   state_nxt_s;
    logic [LAT_CNT_W-1:0]         cnt_r;
    logic [LAT_CNT_W-1:0]         cnt_nxt_s;
    logic                         s_ready_s;
    logic                         shift_en_s;
    logic                         clr_s;
    logic                         capture_s;
    logic                         release_s;
    logic                         emit_s;
    logic                         m_valid_r;
    logic [RES_W-1:0]             m_data_r;
    logic [NTAPS-1:0][DATA_W-1:0] taps_s;
    logic [FILL_W-1:0]            fill_s;
    logic [FILL_W-1:0]            fill_inc_s;

    fir_tap_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en_s),
        .clr      (clr_s),
        .din      (s_data),
        .taps     (taps_s),
        .fill_cnt (fill_s)
    );

    // A sample produces a result unless partial results are disabled and the line is not yet full.
    assign fill_inc_s = fill_inc(fill_s);
    assign emit_s     = (EMIT_PARTIAL != 0) || (fill_inc_s == FILL_FULL);

    // Next-state, wait-window and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        s_ready_s   = 1'b0;
        shift_en_s  = 1'b0;
        clr_s       = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                s_ready_s = !flush;
                if (flush) begin
                    clr_s = 1'b1;
                end else if (s_valid) begin
                    shift_en_s = 1'b1;
                    if (emit_s) begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = LAT_LOAD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {LAT_CNT_W{1'b0}}) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - LAT_CNT_W'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {LAT_CNT_W{1'b0}};
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {LAT_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Result register: loads at the end of the window, drops on the downstream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {RES_W{1'b0}};
        end else if (capture_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= fir_result;
        end else if (release_s) begin
            m_valid_r <= 1'b0;
            m_data_r  <= m_data_r;
        end else begin
            m_valid_r <= m_valid_r;
            m_data_r  <= m_data_r;
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign fill_cnt = fill_s;
    assign tap_0    = taps_s[0];
    assign tap_1    = taps_s[1];
    assign tap_2    = taps_s[2];
    assign tap_3    = taps_s[3];
    assign tap_4    = taps_s[4];
    assign tap_5    = taps_s[5];

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Bench for fir_tap_feeder: two instances (partial emit / FIR_LAT 2, and
// full-line only / FIR_LAT 3) on shared inputs, checked against a timestamp model.
module tb_fir_tap_feeder;

    localparam logic [31:0] BASE = 32'h5A00_0000;

    logic        clk = 1'b0;
    logic        rst, s_valid, flush, m_ready;
    logic [15:0] s_data;
    logic [31:0] fir_result;

    logic [15:0] dtap [2][6];
    logic        d_sready [2];
    logic        d_mvalid [2];
    logic [31:0] d_mdata [2];
    logic [2:0]  d_fill [2];

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    bit cmp_on = 1'b0;
    int dut_hs [2] = '{0, 0};

    // model state: taps, fill, waiting/holding flags, capture edge, result
    int          mt [2][6];
    int          mfill [2] = '{0, 0};
    bit          mbusy [2] = '{1'b0, 1'b0};
    bit          mhold [2] = '{1'b0, 1'b0};
    int          mcap [2] = '{0, 0};
    logic [31:0] mdata [2] = '{32'd0, 32'd0};
    int          medge = 0;

    always #5 clk = ~clk;

    fir_tap_feeder #(.DATA_W(16), .RES_W(32), .FIR_LAT(2), .EMIT_PARTIAL(1)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(d_sready[0]), .s_data(s_data),
        .flush(flush), .tap_0(dtap[0][0]), .tap_1(dtap[0][1]), .tap_2(dtap[0][2]),
        .tap_3(dtap[0][3]), .tap_4(dtap[0][4]), .tap_5(dtap[0][5]), .fir_result(fir_result),
        .m_valid(d_mvalid[0]), .m_ready(m_ready), .m_data(d_mdata[0]), .fill_cnt(d_fill[0]));

    fir_tap_feeder #(.DATA_W(16), .RES_W(32), .FIR_LAT(3), .EMIT_PARTIAL(0)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(d_sready[1]), .s_data(s_data),
        .flush(flush), .tap_0(dtap[1][0]), .tap_1(dtap[1][1]), .tap_2(dtap[1][2]),
        .tap_3(dtap[1][3]), .tap_4(dtap[1][4]), .tap_5(dtap[1][5]), .fir_result(fir_result),
        .m_valid(d_mvalid[1]), .m_ready(m_ready), .m_data(d_mdata[1]), .fill_cnt(d_fill[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock; fir_result changes every cycle so captures are traceable
    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        fir_result = BASE + 32'(tick_no);
    endtask

    task automatic push(input int who, input logic [15:0] v);
        int guard = 0;
        while (!d_sready[who] && guard < 50) begin
            tick();
            guard++;
        end
        chk($sformatf("push_wait dut%0d", who), 32'(d_sready[who]), 32'd1);
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
    endtask

    // model: compare DUT against model state, then advance model over the coming edge
    initial begin
        for (int i = 0; i < 2; i++) for (int k = 0; k < 6; k++) mt[i][k] = 0;
        forever begin
            @(negedge clk);
            medge++;
            if (cmp_on) begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < 6; k++)
                        chk($sformatf("dut%0d tap_%0d", i, k), 32'(dtap[i][k]), 32'(mt[i][k]));
                    chk($sformatf("dut%0d fill_cnt", i), 32'(d_fill[i]), 32'(mfill[i]));
                    chk($sformatf("dut%0d s_ready", i), 32'(d_sready[i]),
                        32'(!mbusy[i] && !mhold[i] && !flush));
                    chk($sformatf("dut%0d m_valid", i), 32'(d_mvalid[i]), 32'(mhold[i]));
                    chk($sformatf("dut%0d m_data", i), d_mdata[i], mdata[i]);
                    if (d_mvalid[i] && m_ready) dut_hs[i]++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    for (int k = 0; k < 6; k++) mt[i][k] = 0;
                    mfill[i] = 0; mbusy[i] = 1'b0; mhold[i] = 1'b0; mdata[i] = 32'd0;
                end else if (mhold[i]) begin
                    if (m_ready) mhold[i] = 1'b0;
                end else if (mbusy[i]) begin
                    if (medge == mcap[i]) begin
                        mdata[i] = fir_result;
                        mbusy[i] = 1'b0;
                        mhold[i] = 1'b1;
                    end
                end else if (flush) begin
                    for (int k = 0; k < 6; k++) mt[i][k] = 0;
                    mfill[i] = 0;
                end else if (s_valid) begin
                    for (int k = 5; k > 0; k--) mt[i][k] = mt[i][k-1];
                    mt[i][0] = int'(s_data);
                    if (mfill[i] < 6) mfill[i]++;
                    if (i == 0 || mfill[i] == 6) begin
                        mbusy[i] = 1'b1;
                        mcap[i]  = medge + ((i == 0) ? 2 : 3);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_acc, hs0;
        logic [31:0] exp_d;
        rst = 1'b1; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
        s_data = 16'd0; fir_result = BASE;
        tick();
        cmp_on = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 6; k++) chk("rst tap", 32'(dtap[0][k]), 32'd0);
        chk("rst fill", 32'(d_fill[0]), 32'd0);
        chk("rst s_ready", 32'(d_sready[0]), 32'd1);
        chk("rst m_valid", 32'(d_mvalid[0]), 32'd0);
        chk("rst m_data", d_mdata[0], 32'd0);

        // single sample, latency 2
        push(0, 16'd3);
        t_acc = tick_no;
        chk("p1 tap_0", 32'(dtap[0][0]), 32'd3);
        for (int k = 1; k < 6; k++) chk("p1 tap_k", 32'(dtap[0][k]), 32'd0);
        chk("p1 fill", 32'(d_fill[0]), 32'd1);
        chk("p1 s_ready T", 32'(d_sready[0]), 32'd0);
        tick();
        chk("p1 m_valid T+1", 32'(d_mvalid[0]), 32'd0);
        chk("p1 s_ready T+1", 32'(d_sready[0]), 32'd0);
        tick();
        chk("p1 m_valid T+2", 32'(d_mvalid[0]), 32'd1);
        chk("p1 m_data", d_mdata[0], BASE + 32'(t_acc + 1));
        chk("p1 s_ready T+2", 32'(d_sready[0]), 32'd0);
        m_ready = 1'b1;
        tick();
        chk("p1 m_valid drop", 32'(d_mvalid[0]), 32'd0);

        // fill and saturate
        flush = 1'b1; tick(); flush = 1'b0;
        hs0 = dut_hs[0];
        for (int v = 1; v <= 6; v++) push(0, 16'(v));
        for (int k = 0; k < 6; k++) chk("fill6 tap", 32'(dtap[0][k]), 32'(6 - k));
        chk("fill6 fill", 32'(d_fill[0]), 32'd6);
        push(0, 16'd7);
        for (int k = 0; k < 6; k++) chk("sat tap", 32'(dtap[0][k]), 32'(7 - k));
        chk("sat fill", 32'(d_fill[0]), 32'd6);
        repeat (6) tick();
        chk("result count", 32'(dut_hs[0] - hs0), 32'd7);

        // backpressure in HOLD
        m_ready = 1'b0;
        push(0, 16'd8);
        t_acc = tick_no;
        exp_d = BASE + 32'(t_acc + 1);
        for (int g = 0; g < 10 && !d_mvalid[0]; g++) tick();
        chk("hold reached", 32'(d_mvalid[0]), 32'd1);
        s_valid = 1'b1; s_data = 16'h0099;
        repeat (5) begin
            tick();
            chk("hold m_data", d_mdata[0], exp_d);
            chk("hold s_ready", 32'(d_sready[0]), 32'd0);
            chk("hold tap_0", 32'(dtap[0][0]), 32'd8);
            chk("hold m_valid", 32'(d_mvalid[0]), 32'd1);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        chk("release m_valid", 32'(d_mvalid[0]), 32'd0);
        chk("release s_ready", 32'(d_sready[0]), 32'd1);

        // flush with simultaneous sample, then flush during WAIT
        flush = 1'b1; tick(); flush = 1'b0;
        for (int v = 11; v <= 14; v++) push(0, 16'(v));
        repeat (4) tick();
        chk("pre-flush fill", 32'(d_fill[0]), 32'd4);
        chk("pre-flush tap_3", 32'(dtap[0][3]), 32'd11);
        flush = 1'b1; s_valid = 1'b1; s_data = 16'd77;
        #1;
        chk("flush s_ready", 32'(d_sready[0]), 32'd0);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush fill", 32'(d_fill[0]), 32'd0);
        for (int k = 0; k < 6; k++) chk("flush tap", 32'(dtap[0][k]), 32'd0);
        push(0, 16'd5);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("wait-flush tap_0", 32'(dtap[0][0]), 32'd5);
        chk("wait-flush fill", 32'(d_fill[0]), 32'd1);
        repeat (4) tick();

        // full-line-only instance, then reset mid-WAIT
        rst = 1'b1; tick(); rst = 1'b0;
        m_ready = 1'b0;
        hs0 = dut_hs[1];
        for (int v = 1; v <= 5; v++) begin
            push(1, 16'(v));
            chk("ep0 no m_valid", 32'(d_mvalid[1]), 32'd0);
            chk("ep0 s_ready", 32'(d_sready[1]), 32'd1);
        end
        tick(); tick();
        chk("ep0 idle m_valid", 32'(d_mvalid[1]), 32'd0);
        push(1, 16'd6);
        t_acc = tick_no;
        chk("ep0 fill", 32'(d_fill[1]), 32'd6);
        chk("ep0 tap_5", 32'(dtap[1][5]), 32'd1);
        chk("ep0 s_ready busy", 32'(d_sready[1]), 32'd0);
        tick(); tick();
        chk("ep0 m_valid T+2", 32'(d_mvalid[1]), 32'd0);
        tick();
        chk("ep0 m_valid T+3", 32'(d_mvalid[1]), 32'd1);
        chk("ep0 m_data", d_mdata[1], BASE + 32'(t_acc + 2));
        m_ready = 1'b1;
        tick();
        chk("ep0 m_valid drop", 32'(d_mvalid[1]), 32'd0);
        chk("ep0 result count", 32'(dut_hs[1] - hs0), 32'd1);
        push(1, 16'd7);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst-wait m_valid", 32'(d_mvalid[1]), 32'd0);
        chk("rst-wait fill", 32'(d_fill[1]), 32'd0);
        chk("rst-wait tap_0", 32'(dtap[1][0]), 32'd0);
        chk("rst-wait m_data", d_mdata[1], 32'd0);
        chk("rst-wait s_ready", 32'(d_sready[1]), 32'd1);
        repeat (4) begin
            tick();
            chk("rst-wait quiet", 32'(d_mvalid[1]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
